// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Holds opcode values, ALU function select codes and state codes.
// Also provides the memory-wait state classifier.
// Optional feature macro: STACK_OPS_EN adds the PUSH/POP state codes.
package ctrl_pkg;

    localparam int CTRL_STATE_W = 5;

    // Instruction opcodes (IR[15:11])
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LD   = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_JMP  = 5'b00111;
    localparam logic [4:0] OP_JZ   = 5'b01000;
    localparam logic [4:0] OP_PUSH = 5'b01001;
    localparam logic [4:0] OP_POP  = 5'b01010;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // ALU function select
    localparam logic [2:0] FN_PASS = 3'b000;
    localparam logic [2:0] FN_ADD  = 3'b001;
    localparam logic [2:0] FN_SUB  = 3'b010;
    localparam logic [2:0] FN_AND  = 3'b011;
    localparam logic [2:0] FN_OR   = 3'b100;
    localparam logic [2:0] FN_INC  = 3'b101;
    localparam logic [2:0] FN_DEC  = 3'b110;

    // The ALU write-back step has one state per operation so that fnSel
    // stays a pure function of the state register.
    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_IDLE   = 5'd0,
        ST_F0     = 5'd1,
        ST_F1     = 5'd2,
        ST_F2     = 5'd3,
        ST_F3     = 5'd4,
        ST_D      = 5'd5,
        ST_L0     = 5'd6,
        ST_L1     = 5'd7,
        ST_L2     = 5'd8,
        ST_L3     = 5'd9,
        ST_S0     = 5'd10,
        ST_S1     = 5'd11,
        ST_S2     = 5'd12,
        ST_A0     = 5'd13,
        ST_A1_ADD = 5'd14,
        ST_A1_SUB = 5'd15,
        ST_A1_AND = 5'd16,
        ST_A1_OR  = 5'd17,
        ST_J0     = 5'd18,
        ST_HALT   = 5'd19,
        ST_FAULT  = 5'd20
`ifdef STACK_OPS_EN
        ,
        ST_P0     = 5'd21,
        ST_P1     = 5'd22,
        ST_P2     = 5'd23,
        ST_P3     = 5'd24,
        ST_Q0     = 5'd25,
        ST_Q1     = 5'd26,
        ST_Q2     = 5'd27,
        ST_Q3     = 5'd28,
        ST_Q4     = 5'd29
`endif
    } state_e;

    // States that hold a memory strobe until mem_ready.
    function automatic logic is_wait_state(input state_e s);
        logic w;
        case (s)
            ST_F1, ST_L1, ST_S2: w = 1'b1;
`ifdef STACK_OPS_EN
            ST_P3, ST_Q1:        w = 1'b1;
`endif
            default:             w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_mem_wait.sv
// Memory wait-state watchdog: counts cycles spent waiting for mem_ready.
// Latency: timeout_o is combinational on the MEM_WAIT_MAX-th waiting cycle.
// Backpressure: none; counter clears whenever not waiting or mem_ready is seen.
// Ports: clk_i/rst_i clock and async active-high reset, wait_i = in a wait
//        state, mem_ready_i = memory completes, timeout_o = give up now.
module ctrl_mem_wait #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait states are never entered back-to-back, so clearing whenever the
    // controller is not stalled guarantees the count starts at 0 on entry.
    always_comb begin
        cnt_d = '0;
        if (wait_i && !mem_ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed stalled cycles; this is the last permitted one.
    assign timeout_o = wait_i && !mem_ready_i &&
                       (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle Moore controller for the 16-bit single-bus datapath.
// Latency (mem_ready=1): NOP 5, JMP 6, ALU 7, ST 8, LD 9 cycles incl. fetch.
// Backpressure: memory states hold their strobe until mem_ready; FAULT after MEM_WAIT_MAX.
// Ports: Clk/Reset (async, active-high); IR, z, mem_ready in; datapath
//        load/drive/memory strobes, fnSel, state, halted, fault out.
// Optional feature macro: STACK_OPS_EN enables PUSH (01001) and POP (01010).
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int STATE_W      = CTRL_STATE_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [15:0]        IR,
    input  logic               z,
    input  logic               mem_ready,
    output logic [2:0]         fnSel,
    output logic               ldMAR,
    output logic               ldIR,
    output logic               ldPC,
    output logic               ldSP,
    output logic               ldMDR,
    output logic               ldReg,
    output logic               ldRegBank,
    output logic               TReg,
    output logic               TRegBank,
    output logic               TSP,
    output logic               TMAR,
    output logic               TPC,
    output logic               TMDR,
    output logic               TLabel,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic               fault
);

    state_e     state_q, state_d;
    logic [4:0] opcode;
    logic       mem_timeout;
    logic       unused_ir;

    assign opcode    = IR[15:11];
    // Register select and immediate are consumed by the datapath only.
    assign unused_ir = ^IR[10:0];

    ctrl_mem_wait #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .wait_i      (is_wait_state(state_q)),
        .mem_ready_i (mem_ready),
        .timeout_o   (mem_timeout)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1:   if (mem_ready) state_d = ST_F2;
            ST_F2:   state_d = ST_F3;
            ST_F3:   state_d = ST_D;
            ST_D: begin
                case (opcode)
                    OP_NOP:                        state_d = ST_F0;
                    OP_LD:                         state_d = ST_L0;
                    OP_ST:                         state_d = ST_S0;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_A0;
                    OP_JMP:                        state_d = ST_J0;
                    OP_JZ:                         state_d = z ? ST_J0 : ST_F0;
                    OP_HALT:                       state_d = ST_HALT;
`ifdef STACK_OPS_EN
                    OP_PUSH:                       state_d = ST_P0;
                    OP_POP:                        state_d = ST_Q0;
`endif
                    default:                       state_d = ST_FAULT;
                endcase
            end
            ST_L0:   state_d = ST_L1;
            ST_L1:   if (mem_ready) state_d = ST_L2;
            ST_L2:   state_d = ST_L3;
            ST_L3:   state_d = ST_F0;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   if (mem_ready) state_d = ST_F0;
            // IR is stable for the whole instruction, so A0 can pick the op.
            ST_A0: begin
                case (opcode)
                    OP_ADD:  state_d = ST_A1_ADD;
                    OP_SUB:  state_d = ST_A1_SUB;
                    OP_AND:  state_d = ST_A1_AND;
                    OP_OR:   state_d = ST_A1_OR;
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_A1_ADD, ST_A1_SUB, ST_A1_AND, ST_A1_OR: state_d = ST_F0;
            ST_J0:    state_d = ST_F0;
`ifdef STACK_OPS_EN
            ST_P0:    state_d = ST_P1;
            ST_P1:    state_d = ST_P2;
            ST_P2:    state_d = ST_P3;
            ST_P3:    if (mem_ready) state_d = ST_F0;
            ST_Q0:    state_d = ST_Q1;
            ST_Q1:    if (mem_ready) state_d = ST_Q2;
            ST_Q2:    state_d = ST_Q3;
            ST_Q3:    state_d = ST_Q4;
            ST_Q4:    state_d = ST_F0;
`endif
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
        // Only asserted in a wait state; overrides the hold above.
        if (mem_timeout) begin
            state_d = ST_FAULT;
        end
    end

    // Output decode: strictly a function of state_q
    always_comb begin
        fnSel     = FN_PASS;
        ldMAR     = 1'b0;
        ldIR      = 1'b0;
        ldPC      = 1'b0;
        ldSP      = 1'b0;
        ldMDR     = 1'b0;
        ldReg     = 1'b0;
        ldRegBank = 1'b0;
        TReg      = 1'b0;
        TRegBank  = 1'b0;
        TSP       = 1'b0;
        TMAR      = 1'b0;
        TPC       = 1'b0;
        TMDR      = 1'b0;
        TLabel    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_F0:     begin TPC = 1'b1; ldMAR = 1'b1; end
            ST_F1:     MemRead = 1'b1;
            ST_F2:     begin IRWrite = 1'b1; ldIR = 1'b1; end
            ST_F3:     begin TPC = 1'b1; fnSel = FN_INC; ldPC = 1'b1; end
            ST_L0:     begin TLabel = 1'b1; ldMAR = 1'b1; end
            ST_L1:     MemRead = 1'b1;
            ST_L2:     ldMDR = 1'b1;
            ST_L3:     begin TMDR = 1'b1; ldRegBank = 1'b1; end
            ST_S0:     begin TLabel = 1'b1; ldMAR = 1'b1; end
            ST_S1:     begin TRegBank = 1'b1; ldMDR = 1'b1; end
            ST_S2:     MemWrite = 1'b1;
            ST_A0:     begin TRegBank = 1'b1; ldReg = 1'b1; end
            ST_A1_ADD: begin TLabel = 1'b1; fnSel = FN_ADD; ldRegBank = 1'b1; end
            ST_A1_SUB: begin TLabel = 1'b1; fnSel = FN_SUB; ldRegBank = 1'b1; end
            ST_A1_AND: begin TLabel = 1'b1; fnSel = FN_AND; ldRegBank = 1'b1; end
            ST_A1_OR:  begin TLabel = 1'b1; fnSel = FN_OR;  ldRegBank = 1'b1; end
            ST_J0:     begin TLabel = 1'b1; fnSel = FN_PASS; ldPC = 1'b1; end
`ifdef STACK_OPS_EN
            ST_P0:     begin TSP = 1'b1; fnSel = FN_DEC; ldSP = 1'b1; end
            ST_P1:     begin TSP = 1'b1; ldMAR = 1'b1; end
            ST_P2:     begin TRegBank = 1'b1; ldMDR = 1'b1; end
            ST_P3:     MemWrite = 1'b1;
            ST_Q0:     begin TSP = 1'b1; ldMAR = 1'b1; end
            ST_Q1:     MemRead = 1'b1;
            ST_Q2:     ldMDR = 1'b1;
            ST_Q3:     begin TMDR = 1'b1; ldRegBank = 1'b1; end
            ST_Q4:     begin TSP = 1'b1; fnSel = FN_INC; ldSP = 1'b1; end
`endif
            ST_HALT:   halted = 1'b1;
            ST_FAULT:  fault = 1'b1;
            default:   ;
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
module tb_control_sequencer;
    import ctrl_pkg::*;

    localparam int MAXW = 15;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IR = 16'h0;
    logic        z = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  fnSel;
    logic        ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank;
    logic        TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel;
    logic        MemRead, MemWrite, IRWrite, halted, fault;
    logic [4:0]  state;

    control_sequencer #(.MEM_WAIT_MAX(MAXW), .STATE_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .z(z), .mem_ready(mem_ready),
        .fnSel(fnSel), .ldMAR(ldMAR), .ldIR(ldIR), .ldPC(ldPC), .ldSP(ldSP),
        .ldMDR(ldMDR), .ldReg(ldReg), .ldRegBank(ldRegBank), .TReg(TReg),
        .TRegBank(TRegBank), .TSP(TSP), .TMAR(TMAR), .TPC(TPC), .TMDR(TMDR),
        .TLabel(TLabel), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .state(state), .halted(halted), .fault(fault)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit bus_en = 1'b0;

    // Observed output vector: {fnSel, 7 loads, 7 drives, 3 memory, halted, fault}
    localparam logic [21:0] M_LDMAR     = 22'd1 << 18;
    localparam logic [21:0] M_LDIR      = 22'd1 << 17;
    localparam logic [21:0] M_LDPC      = 22'd1 << 16;
    localparam logic [21:0] M_LDSP      = 22'd1 << 15;
    localparam logic [21:0] M_LDMDR     = 22'd1 << 14;
    localparam logic [21:0] M_LDREG     = 22'd1 << 13;
    localparam logic [21:0] M_LDREGBANK = 22'd1 << 12;
    localparam logic [21:0] M_TREGBANK  = 22'd1 << 10;
    localparam logic [21:0] M_TSP       = 22'd1 << 9;
    localparam logic [21:0] M_TPC       = 22'd1 << 7;
    localparam logic [21:0] M_TMDR      = 22'd1 << 6;
    localparam logic [21:0] M_TLABEL    = 22'd1 << 5;
    localparam logic [21:0] M_MEMREAD   = 22'd1 << 4;
    localparam logic [21:0] M_MEMWRITE  = 22'd1 << 3;
    localparam logic [21:0] M_IRWRITE   = 22'd1 << 2;
    localparam logic [21:0] M_HALTED    = 22'd1 << 1;
    localparam logic [21:0] M_FAULT     = 22'd1;

    function automatic logic [21:0] fn(input logic [2:0] f);
        return {f, 19'd0};
    endfunction

    function automatic logic [21:0] obs();
        return {fnSel, ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank,
                TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel,
                MemRead, MemWrite, IRWrite, halted, fault};
    endfunction

    // Reference model: the micro-step list an instruction must walk through.
    logic [21:0] prog_out [0:15];
    bit          prog_wait [0:15];
    int          prog_n;
    int          prog_term;   // 0 back to fetch, 1 halted, 2 fault

    task automatic add(input logic [21:0] o, input bit w);
        prog_out[prog_n]  = o;
        prog_wait[prog_n] = w;
        prog_n++;
    endtask

    task automatic build(input logic [4:0] op, input logic zz);
        prog_n = 0;
        prog_term = 0;
        add(M_TPC | M_LDMAR, 0);
        add(M_MEMREAD, 1);
        add(M_IRWRITE | M_LDIR, 0);
        add(M_TPC | M_LDPC | fn(FN_INC), 0);
        add(22'd0, 0);
        case (op)
            OP_NOP: ;
            OP_LD: begin
                add(M_TLABEL | M_LDMAR, 0); add(M_MEMREAD, 1);
                add(M_LDMDR, 0);            add(M_TMDR | M_LDREGBANK, 0);
            end
            OP_ST: begin
                add(M_TLABEL | M_LDMAR, 0); add(M_TREGBANK | M_LDMDR, 0);
                add(M_MEMWRITE, 1);
            end
            OP_ADD: begin add(M_TREGBANK | M_LDREG, 0); add(M_TLABEL | M_LDREGBANK | fn(FN_ADD), 0); end
            OP_SUB: begin add(M_TREGBANK | M_LDREG, 0); add(M_TLABEL | M_LDREGBANK | fn(FN_SUB), 0); end
            OP_AND: begin add(M_TREGBANK | M_LDREG, 0); add(M_TLABEL | M_LDREGBANK | fn(FN_AND), 0); end
            OP_OR:  begin add(M_TREGBANK | M_LDREG, 0); add(M_TLABEL | M_LDREGBANK | fn(FN_OR), 0); end
            OP_JMP: add(M_TLABEL | M_LDPC | fn(FN_PASS), 0);
            OP_JZ:  if (zz) add(M_TLABEL | M_LDPC | fn(FN_PASS), 0);
            OP_HALT: prog_term = 1;
`ifdef STACK_OPS_EN
            OP_PUSH: begin
                add(M_TSP | M_LDSP | fn(FN_DEC), 0); add(M_TSP | M_LDMAR, 0);
                add(M_TREGBANK | M_LDMDR, 0);        add(M_MEMWRITE, 1);
            end
            OP_POP: begin
                add(M_TSP | M_LDMAR, 0);      add(M_MEMREAD, 1);
                add(M_LDMDR, 0);              add(M_TMDR | M_LDREGBANK, 0);
                add(M_TSP | M_LDSP | fn(FN_INC), 0);
            end
`endif
            default: prog_term = 2;
        endcase
    endtask

    function automatic int spec_latency(input logic [4:0] op, input logic zz);
        case (op)
            OP_NOP: return 5;
            OP_JMP: return 6;
            OP_ADD, OP_SUB, OP_AND, OP_OR: return 7;
            OP_ST:  return 8;
            OP_LD:  return 9;
            OP_JZ:  return zz ? 6 : 5;
            OP_PUSH: return 9;
            OP_POP:  return 10;
            default: return 0;
        endcase
    endfunction

    function automatic logic [4:0] rand_legal_op();
`ifdef STACK_OPS_EN
        case ($urandom_range(0, 10))
`else
        case ($urandom_range(0, 8))
`endif
            0: return OP_NOP;
            1: return OP_LD;
            2: return OP_ST;
            3: return OP_ADD;
            4: return OP_SUB;
            5: return OP_AND;
            6: return OP_OR;
            7: return OP_JMP;
            8: return OP_JZ;
            9: return OP_PUSH;
            default: return OP_POP;
        endcase
    endfunction

    // Bus rule watched every cycle, independent of the scenario running.
    always @(negedge Clk) begin
        if (bus_en && !Reset) begin
            checks++;
            if ($countones({TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel}) > 1 ||
                (MemRead && MemWrite)) begin
                errors++;
                $display("FAIL bus_rule t=%0t drives=%b rd=%b wr=%b", $time,
                         {TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel}, MemRead, MemWrite);
            end
        end
    end

    // Called at a negedge with the DUT in F0; returns at a negedge in F0,
    // or after confirming HALT/FAULT are absorbing. low<0 picks random stalls.
    task automatic exec(input logic [15:0] ir, input logic zz, input int low, output int term);
        int  lows, wcnt;
        bit  rdy, done, stop;
        logic [21:0] exp_v;
        build(ir[15:11], zz);
        IR = ir;
        z = zz;
        term = prog_term;
        stop = 0;
        for (int i = 0; i < prog_n && !stop; i++) begin
            lows = (low < 0) ? int'($urandom_range(0, 4)) : low;
            wcnt = 0;
            done = 0;
            while (!done) begin
                checks++;
                if (obs() !== prog_out[i]) begin
                    errors++;
                    $display("FAIL seq ir=%h step=%0d wait=%0d got=%h want=%h",
                             ir, i, wcnt, obs(), prog_out[i]);
                end
                rdy = prog_wait[i] ? (wcnt >= lows) : 1'($urandom_range(0, 1));
                mem_ready = rdy;
                @(negedge Clk);
                if (!prog_wait[i] || rdy) done = 1;
                else begin
                    wcnt++;
                    if (wcnt == MAXW) begin
                        term = 2;
                        done = 1;
                        stop = 1;
                    end
                end
            end
        end
        if (term != 0) begin
            exp_v = (term == 1) ? M_HALTED : M_FAULT;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs() !== exp_v) begin
                    errors++;
                    $display("FAIL terminal ir=%h cyc=%0d got=%h want=%h", ir, k, obs(), exp_v);
                end
                mem_ready = 1'($urandom_range(0, 1));
                z = 1'($urandom_range(0, 1));
                IR = 16'($urandom);
                @(negedge Clk);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where the DUT sits in F0.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 22'd0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_async got=%h state=%0d want=0 state=%0d", obs(), state, ST_IDLE);
        end
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if (obs() !== 22'd0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_idle got=%h state=%0d", obs(), state);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        do_reset();
        bus_en = 1'b1;
        checks++;
        if (obs() !== (M_TPC | M_LDMAR)) begin
            errors++;
            $display("FAIL reset_to_f0 got=%h want=%h", obs(), M_TPC | M_LDMAR);
        end
    endtask

    task automatic test_nop();
        int t;
        exec(16'h0000, 1'b0, 0, t);
        exec(16'h0000, 1'b1, 0, t);
    endtask

    task automatic test_ld_wait();
        int t;
        exec({OP_LD, 11'h123}, 1'b0, 3, t);
    endtask

    task automatic test_jz();
        int t;
        exec(16'h4055, 1'b1, 0, t);
        exec(16'h4055, 1'b0, 0, t);
    endtask

    task automatic test_latency();
        int cyc;
        logic [4:0] op;
        logic zz;
        for (int k = 0; k < 14; k++) begin
            op = rand_legal_op();
            zz = 1'($urandom_range(0, 1));
            IR = {op, 11'($urandom)};
            z = zz;
            mem_ready = 1'b1;
            cyc = 0;
            do begin
                @(negedge Clk);
                cyc++;
            end while (!(TPC && ldMAR) && cyc < 40);
            checks++;
            if (cyc != spec_latency(op, zz)) begin
                errors++;
                $display("FAIL latency op=%b z=%b got=%0d want=%0d", op, zz, cyc, spec_latency(op, zz));
            end
        end
    endtask

    task automatic test_random();
        int t;
        for (int k = 0; k < 30; k++) begin
            exec({rand_legal_op(), 11'($urandom)}, 1'($urandom_range(0, 1)), -1, t);
        end
    endtask

    task automatic test_timeout();
        int t;
        // Ready on the last permitted waiting cycle: must not fault.
        exec({OP_NOP, 11'($urandom)}, 1'b0, MAXW - 1, t);
        exec({OP_LD, 11'($urandom)}, 1'b0, 1000, t);
        checks++;
        if (fault !== 1'b1 || state !== ST_FAULT) begin
            errors++;
            $display("FAIL timeout_sticky fault=%b state=%0d", fault, state);
        end
        do_reset();
        exec({OP_NOP, 11'($urandom)}, 1'b0, 1000, t);
        do_reset();
    endtask

    task automatic test_halt();
        int t;
        exec({OP_HALT, 11'($urandom)}, 1'b0, -1, t);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0 || state !== ST_HALT) begin
            errors++;
            $display("FAIL halt_state halted=%b fault=%b state=%0d", halted, fault, state);
        end
        do_reset();
    endtask

    task automatic test_bad_opcode();
        int t;
        for (int k = 0; k < 3; k++) begin
            exec({5'($urandom_range(11, 30)), 11'($urandom)}, 1'($urandom_range(0, 1)), -1, t);
            do_reset();
        end
    endtask

    task automatic test_stack();
        int t;
        exec({OP_PUSH, 11'($urandom)}, 1'b0, -1, t);
        if (t != 0) do_reset();
        exec({OP_POP, 11'($urandom)}, 1'b0, -1, t);
        if (t != 0) do_reset();
    endtask

    task automatic test_reset_mid_ld();
        IR = {OP_LD, 11'h0A5};
        z = 1'b0;
        mem_ready = 1'b1;
        repeat (6) @(negedge Clk);
        checks++;
        if (obs() !== M_MEMREAD) begin
            errors++;
            $display("FAIL mid_ld_l1 got=%h want=%h", obs(), M_MEMREAD);
        end
        mem_ready = 1'b0;
        do_reset();
        checks++;
        if (obs() !== (M_TPC | M_LDMAR)) begin
            errors++;
            $display("FAIL mid_ld_f0 got=%h want=%h", obs(), M_TPC | M_LDMAR);
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_ld_wait();
        test_jz();
        test_latency();
        test_random();
        test_timeout();
        test_halt();
        test_bad_opcode();
        test_stack();
        test_reset_mid_ld();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
